// File: rtl/sum_merge_fifo.sv
// rtl/sum_merge_fifo.sv - inter-core partial-sum merge buffer
//
// Captures one batch of local and one batch of peer row-sum words in two
// side FIFOs. Once both batches are complete it raises ready_o, then presents
// local head + peer head on sum_o and pops both sides on every div_rd.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   local_wr, local_in   local core sum word and write strobe
//   peer_wr, peer_in     peer core sum word and write strobe
//   div_rd               pop strobe from the controller divide phase
//   sum_o                merged sum (0 while filling)
//   ready_o              both batches complete, waiting for the first pop
//   local_full/peer_full side FIFO holds depth entries
//   err_o                sticky: write to a full side or div_rd while filling
//
// Compile option: SUM_MERGE_SAT_EN saturates sum_o to all ones on carry-out;
// without it the sum wraps modulo 2^(bw_psum+4).
module sum_merge_fifo #(
  parameter int bw_psum     = 20,
  parameter int depth       = 16,
  parameter int total_cycle = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 local_wr,
  input  logic [bw_psum+3:0]   local_in,
  input  logic                 peer_wr,
  input  logic [bw_psum+3:0]   peer_in,
  input  logic                 div_rd,
  output logic [bw_psum+3:0]   sum_o,
  output logic                 ready_o,
  output logic                 local_full,
  output logic                 peer_full,
  output logic                 err_o
);

  localparam int W  = bw_psum + 4;
  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C  = PW'(depth);
  localparam logic [PW-1:0] TC_C     = PW'(total_cycle);
  localparam logic [4:0]    CNT_LAST = 5'(total_cycle - 1);

  typedef enum logic [1:0] {FILL, READY, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  lwp_q, lwp_d, lrp_q, lrp_d;
  logic [PW-1:0]  pwp_q, pwp_d, prp_q, prp_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           ready_q, ready_d;

  logic [W-1:0]   local_mem_q [depth];
  logic [W-1:0]   peer_mem_q  [depth];

  logic [PW-1:0]  l_cnt, p_cnt, l_cnt_n, p_cnt_n;
  logic           l_push, p_push, pop;
  logic [W-1:0]   l_head, p_head;

  always_comb begin
    l_cnt      = lwp_q - lrp_q;
    p_cnt      = pwp_q - prp_q;
    local_full = (l_cnt == DEPTH_C);
    peer_full  = (p_cnt == DEPTH_C);

    l_push = local_wr && !local_full;
    p_push = peer_wr && !peer_full;
    // Both sides always pop together; FILL never pops.
    pop    = div_rd && (state_q != FILL);

    lwp_d = lwp_q + PW'(l_push);
    pwp_d = pwp_q + PW'(p_push);
    lrp_d = lrp_q + PW'(pop);
    prp_d = prp_q + PW'(pop);

    // Next-cycle occupancy lets ready_o rise right after the completing write.
    l_cnt_n = lwp_d - lrp_d;
    p_cnt_n = pwp_d - prp_d;

    err_d = err_q
          | (local_wr && local_full)
          | (peer_wr && peer_full)
          | (div_rd && (state_q == FILL));

    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FILL: begin
        if ((l_cnt_n >= TC_C) && (p_cnt_n >= TC_C)) state_d = READY;
      end
      READY, DRAIN: begin
        // cnt_q is 0 in READY, so the first pop shares the DRAIN path.
        if (pop) begin
          if (cnt_q == CNT_LAST) begin
            state_d = FILL;
            cnt_d   = '0;
          end else begin
            state_d = DRAIN;
            cnt_d   = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == READY);

    l_head = local_mem_q[lrp_q[AW-1:0]];
    p_head = peer_mem_q[prp_q[AW-1:0]];
  end

`ifdef SUM_MERGE_SAT_EN
  logic [W:0] sum_wide;
  always_comb begin
    sum_wide = {1'b0, l_head} + {1'b0, p_head};
    if (state_q == FILL)  sum_o = '0;
    else if (sum_wide[W]) sum_o = '1;
    else                  sum_o = sum_wide[W-1:0];
  end
`else
  always_comb begin
    if (state_q == FILL) sum_o = '0;
    else                 sum_o = l_head + p_head;
  end
`endif

  assign ready_o = ready_q;
  assign err_o   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      lwp_q   <= '0;
      lrp_q   <= '0;
      pwp_q   <= '0;
      prp_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lwp_q   <= lwp_d;
      lrp_q   <= lrp_d;
      pwp_q   <= pwp_d;
      prp_q   <= prp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (l_push) local_mem_q[lwp_q[AW-1:0]] <= local_in;
    if (p_push) peer_mem_q[pwp_q[AW-1:0]]  <= peer_in;
  end

endmodule

// File: tb/tb_sum_merge_fifo.sv
// tb/tb_sum_merge_fifo.sv - randomized self-checking bench for sum_merge_fifo
module tb_sum_merge_fifo;

  localparam int W     = 24;
  localparam int DEPTH = 16;
  localparam int TC    = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         local_wr, peer_wr, div_rd;
  logic [W-1:0] local_in, peer_in;
  logic [W-1:0] sum_o;
  logic         ready_o, local_full, peer_full, err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sum_merge_fifo #(.bw_psum(20), .depth(DEPTH), .total_cycle(TC)) dut (
    .clk(clk), .reset(reset),
    .local_wr(local_wr), .local_in(local_in),
    .peer_wr(peer_wr), .peer_in(peer_in),
    .div_rd(div_rd),
    .sum_o(sum_o), .ready_o(ready_o),
    .local_full(local_full), .peer_full(peer_full), .err_o(err_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 0 = filling, 1 = batch ready, 2 = draining.
  int           m_state;
  int           m_pops;
  bit           m_err;
  logic [W-1:0] lq[$];
  logic [W-1:0] pq[$];

  function automatic logic [W-1:0] model_sum();
    longint s;
    if (m_state == 0) return '0;
    s = longint'(lq[0]) + longint'(pq[0]);
`ifdef SUM_MERGE_SAT_EN
    if (s > 64'hFFFFFF) s = 64'hFFFFFF;
`else
    s = s % (64'd1 << W);
`endif
    return W'(s);
  endfunction

  task automatic model_step(input logic lw, input logic [W-1:0] lin, input logic pw,
                            input logic [W-1:0] pin, input logic rd, input logic rst);
    bit was_fill, lf, pf;
    if (rst) begin
      lq.delete(); pq.delete();
      m_state = 0; m_pops = 0; m_err = 0;
      return;
    end
    was_fill = (m_state == 0);
    lf = (lq.size() == DEPTH);
    pf = (pq.size() == DEPTH);
    if (rd && was_fill) m_err = 1;
    if (rd && !was_fill) begin
      void'(lq.pop_front());
      void'(pq.pop_front());
      m_pops++;
      m_state = 2;
      if (m_pops == TC) begin
        m_state = 0;
        m_pops  = 0;
      end
    end
    if (lw) begin
      if (lf) m_err = 1; else lq.push_back(lin);
    end
    if (pw) begin
      if (pf) m_err = 1; else pq.push_back(pin);
    end
    if (was_fill && lq.size() >= TC && pq.size() >= TC) m_state = 1;
  endtask

  // One clock: drive, compare pre-edge outputs at negedge, advance model.
  task automatic cycle(input logic lw, input logic [W-1:0] lin, input logic pw,
                       input logic [W-1:0] pin, input logic rd, input logic rst);
    reset = rst; local_wr = lw; local_in = lin; peer_wr = pw; peer_in = pin; div_rd = rd;
    @(negedge clk);
    check_eq("sum_o", sum_o, model_sum());
    check_eq("ready_o", ready_o, m_state == 1);
    check_eq("local_full", local_full, lq.size() == DEPTH);
    check_eq("peer_full", peer_full, pq.size() == DEPTH);
    check_eq("err_o", err_o, m_err);
    @(posedge clk);
    model_step(lw, lin, pw, pin, rd, rst);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  // Local i, peer 100+i lagging 3 cycles; ready right after the last peer write.
  task automatic run_batch1(input string tag);
    for (int t = 0; t < TC + 3; t++) begin
      cycle(t < TC, W'(t), t >= 3, W'(100 + t - 3), 1'b0, 1'b0);
      check_eq({tag, "_ready_lat"}, ready_o, t == TC + 2);
    end
    for (int i = 0; i < TC; i++) begin
      check_eq({tag, "_sum"}, sum_o, 100 + 2 * i);
      cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    end
    check_eq({tag, "_fill_sum"}, sum_o, 0);
    check_eq({tag, "_fill_ready"}, ready_o, 0);
    check_eq({tag, "_err"}, err_o, 0);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, W'($urandom), 1'b1, W'($urandom), 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; local_wr = 0; peer_wr = 0; div_rd = 0; local_in = '0; peer_in = '0;
    m_state = 0; m_pops = 0; m_err = 0;
    @(posedge clk); #1;
    do_reset();
    check_eq("rst_sum", sum_o, 0);
    check_eq("rst_ready", ready_o, 0);
    check_eq("rst_lfull", local_full, 0);
    check_eq("rst_pfull", peer_full, 0);
    check_eq("rst_err", err_o, 0);

    run_batch1("b1");

    // Carry-out on the first merged word.
    do_reset();
    cycle(1'b1, 24'hFFFFF0, 1'b1, 24'h000020, 1'b0, 1'b0);
    fill_random(TC - 1);
`ifdef SUM_MERGE_SAT_EN
    check_eq("wrap_sum", sum_o, 32'h00FFFFFF);
`else
    check_eq("wrap_sum", sum_o, 32'h00000010);
`endif
    drain(TC);

    // Overflow on the local side.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, W'(i + 7), 1'b0, '0, 1'b0, 1'b0);
    check_eq("ovf_full", local_full, 1);
    check_eq("ovf_err_before", err_o, 0);
    cycle(1'b1, 24'hABCDEF, 1'b0, '0, 1'b0, 1'b0);
    check_eq("ovf_err", err_o, 1);
    for (int i = 0; i < 4; i++) idle();
    check_eq("ovf_err_held", err_o, 1);
    for (int i = 0; i < TC; i++) cycle(1'b0, '0, 1'b1, W'(i), 1'b0, 1'b0);
    check_eq("ovf_first_sum", sum_o, 7);
    drain(TC);
    check_eq("ovf_err_sticky", err_o, 1);

    // div_rd during FILL must not move pointers.
    do_reset();
    fill_random(5);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    check_eq("fillrd_err", err_o, 1);
    check_eq("fillrd_ready", ready_o, 0);
    fill_random(TC - 5);
    drain(TC);

    // Second batch written while the first drains.
    do_reset();
    fill_random(TC);
    check_eq("conc_ready1", ready_o, 1);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 1; i < TC; i++) cycle(1'b1, W'(1000 + i), 1'b1, W'(2000 + i), 1'b1, 1'b0);
    cycle(1'b1, W'(1016), 1'b1, W'(2016), 1'b0, 1'b0);
    check_eq("conc_ready2", ready_o, 1);
    check_eq("conc_err", err_o, 0);
    for (int i = 1; i <= TC; i++) begin
      check_eq("conc_sum", sum_o, 3000 + 2 * i);
      cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    end
    check_eq("conc_err_end", err_o, 0);

    // Reset after 8 pops, then a clean batch.
    do_reset();
    fill_random(TC);
    drain(8);
    do_reset();
    check_eq("midrst_ready", ready_o, 0);
    check_eq("midrst_sum", sum_o, 0);
    check_eq("midrst_lfull", local_full, 0);
    check_eq("midrst_err", err_o, 0);
    run_batch1("b2");

    // Random traffic against the model.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 600; c++) begin
        logic rd;
        rd = (m_state == 0) ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 1) == 1);
        cycle($urandom_range(0, 2) == 0, W'($urandom), $urandom_range(0, 2) == 0,
              W'($urandom), rd, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
